vrased_reset_ctrl: RTL
======================

# vrased_reset_ctrl

Reset controller that sits directly downstream of the VRASED hardware monitors (execution-stack monitor, atomicity monitor, DMA monitor). It collects their per-monitor `reset` requests, stretches any request into a system reset of guaranteed minimum width, and holds it until every source has withdrawn. It also records which monitor(s) caused the reset. Its `sys_reset` output drives the openMSP430 reset input, so any monitor violation becomes a clean, deterministic MCU reset.

## Interface
- `RST_CYCLES`, 16: minimum `sys_reset` high time in clock cycles, valid range 1..255.
- `CNT_W`, 8: width of the saturating violation counter.

- `clk`  in  1  system clock, shared with the monitors.
- `rst`  in  1  asynchronous, active-high reset (power-on/external).
- `xs_reset`  in  1  reset request from the execution-stack monitor.
- `ac_reset`  in  1  reset request from the atomicity monitor.
- `dma_reset`  in  1  reset request from the DMA monitor.
- `cause_clr`  in  1  single-cycle pulse; clears the cause log and the counter.
- `sys_reset`  out  1  registered reset to the MCU core.
- `busy`  out  1  high in any state other than IDLE.
- `cause`  out  3  sticky cause bits, one per source: [0]=xs, [1]=ac, [2]=dma.
- `viol_cnt`  out  CNT_W  saturating count of reset episodes.

## Operation
- `req = xs_reset | ac_reset | dma_reset`, evaluated combinationally.
- FSM states: IDLE, ASSERT, HOLD.
  - IDLE: if `req`, go to ASSERT, load the stretch counter with `RST_CYCLES-1`, and set `sys_reset`.
  - ASSERT: decrement the counter every cycle. At 0, go to HOLD if `req` is still high, otherwise go to IDLE and clear `sys_reset`.
  - HOLD: keep `sys_reset` high. Go to IDLE and clear `sys_reset` on the first cycle with `req` low.
- A new `req` in ASSERT or HOLD is absorbed into the current episode: no restart and no extra count.
- Cause log: while in any state, every cycle ORs `{dma_reset, ac_reset, xs_reset}` into `cause`.
- `viol_cnt` increments by 1 on each IDLE→ASSERT transition and saturates at all-ones.
- `cause_clr` clears `cause` and `viol_cnt` and has priority over a same-cycle set or increment. It has no effect on the FSM or `sys_reset`.
- Reset values: state=IDLE, `sys_reset`=0, `busy`=0, `cause`=0, `viol_cnt`=0, stretch counter=0.
- `rst` asserted mid-episode forces all of the above immediately (asynchronously). After `rst` deasserts, a still-high `req` starts a fresh episode.

## Timing
- Latency: `req` rising at edge N is sampled there; `sys_reset` is high from edge N onward (visible after edge N).
- Minimum width: `sys_reset` stays high for exactly `RST_CYCLES` cycles when `req` drops before the counter expires.
- Release: `sys_reset` falls at the first edge where the FSM is in HOLD (or at ASSERT count 0) and `req` is sampled low.
- `busy` equals `sys_reset` cycle-for-cycle.
- `cause` and `viol_cnt` update on the same edge as the triggering sample.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `VRASED_RST_CAUSE_LOG_EN` defined: the cause log and `viol_cnt` are built as described above.
- Not defined: `cause` and `viol_cnt` are tied to 0, the logging registers are removed, and `cause_clr` is ignored. FSM, stretch and `sys_reset` behaviour are identical in both builds.

## Test plan
- 1-cycle `xs_reset` pulse, `RST_CYCLES`=16:
  - `sys_reset` is high for exactly 16 cycles, then returns to 0.
  - `cause`=3'b001 and `viol_cnt`=1.
- `ac_reset` held 40 cycles:
  - `sys_reset` stays high through HOLD and falls on the first edge after `ac_reset` drops, for 40 cycles total.
  - `viol_cnt`=1.
- `xs_reset` at cycle 0, `dma_reset` at cycle 5 within the same episode:
  - single episode; `cause`=3'b101 and `viol_cnt`=1.
- 256 separate episodes with `CNT_W`=8 → `viol_cnt` saturates at 8'hFF.
- `cause_clr` in the same cycle as a new `xs_reset` → `cause`=0 and `viol_cnt`=0, while `sys_reset` still asserts.
- `rst` asserted during ASSERT, with `dma_reset` still high at release:
  - all outputs go to 0 asynchronously.
  - After release, a new episode starts on the next edge with `viol_cnt`=1.
  - Repeat without `VRASED_RST_CAUSE_LOG_EN`: `cause`=0 and `viol_cnt`=0 throughout.

Source files
------------

// File: rtl/vrased_reset_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vrased_reset_ctrl_if
// Description : Request/status bundle between the VRASED monitors and the
//               reset controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface vrased_reset_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             xs_reset;
  logic             ac_reset;
  logic             dma_reset;
  logic             cause_clr;
  logic             sys_reset;
  logic             busy;
  logic [2:0]       cause;
  logic [CNT_W-1:0] viol_cnt;

  modport master (
    output xs_reset, ac_reset, dma_reset, cause_clr,
    input  sys_reset, busy, cause, viol_cnt
  );

  modport slave (
    input  xs_reset, ac_reset, dma_reset, cause_clr,
    output sys_reset, busy, cause, viol_cnt
  );
endinterface
`default_nettype wire

// File: rtl/vrased_reset_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vrased_reset_ctrl
// Description : Stretches VRASED monitor reset requests into a minimum-width
//               MCU reset and logs the causes. Optional cause log / episode
//               counter enabled by defining VRASED_RST_CAUSE_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vrased_reset_ctrl #(
  parameter int RST_CYCLES = 16,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  vrased_reset_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] C_STRETCH_INIT = 8'(RST_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_stretch;
  logic       r_sys_reset;
  logic       r_busy;
  logic       w_req;

  assign w_req = bus.xs_reset | bus.ac_reset | bus.dma_reset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stretch   <= 8'd0;
      r_sys_reset <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state     <= S_ASSERT;
            r_stretch   <= C_STRETCH_INIT;
            r_sys_reset <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (r_stretch == 8'd0) begin
            if (w_req) begin
              r_state <= S_HOLD;
            end else begin
              r_state     <= S_IDLE;
              r_sys_reset <= 1'b0;
              r_busy      <= 1'b0;
            end
          end else begin
            r_stretch <= r_stretch - 8'd1;
          end
        end
        S_HOLD: begin
          if (!w_req) begin
            r_state     <= S_IDLE;
            r_sys_reset <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_sys_reset <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sys_reset = r_sys_reset;
  assign bus.busy      = r_busy;

`ifdef VRASED_RST_CAUSE_LOG_EN
  logic [2:0]       r_cause;
  logic [CNT_W-1:0] r_viol_cnt;

  // A clear wins over any same-cycle cause bit or episode count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cause    <= 3'b000;
      r_viol_cnt <= '0;
    end else if (bus.cause_clr) begin
      r_cause    <= 3'b000;
      r_viol_cnt <= '0;
    end else begin
      r_cause <= r_cause | {bus.dma_reset, bus.ac_reset, bus.xs_reset};
      if ((r_state == S_IDLE) && w_req && (r_viol_cnt != {CNT_W{1'b1}})) begin
        r_viol_cnt <= r_viol_cnt + 1'b1;
      end
    end
  end

  assign bus.cause    = r_cause;
  assign bus.viol_cnt = r_viol_cnt;
`else
  logic unused_cause_clr;

  assign unused_cause_clr = bus.cause_clr;
  assign bus.cause        = 3'b000;
  assign bus.viol_cnt     = '0;
`endif

endmodule
`default_nettype wire
